fft8_frame_ctrl: RTL and testbench

- Sequencing controller for the combinational 8-point dual-channel (I/Q) FFT datapath.
- Collects 8 serial I/Q samples into a frame and drives the 128-bit fft_in_phase/fft_in_quad buses.
- Waits FFT_LAT cycles, captures fft_out_phase/fft_out_quad, then streams the 8 bins out serially with valid/ready backpressure.
- Sits between the OFDM sample stream (upstream mapper) and the downstream bin consumer.

---
 rtl/fft8_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fft8_frame_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl
//   Frames a serial I/Q sample stream for a combinational (or pipelined)
//   8-point FFT. It gathers eight samples into the fft_in buses, waits
//   FFT_LAT cycles, captures the FFT result and streams the eight bins out
//   with valid/ready flow control. Input is stalled while a frame is being
//   computed or drained, so frames never overlap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FILL    | accepting samples into fft_in_*; s_ready high
//   COMPUTE | fft_in_* held stable, latency counter running
//   DRAIN   | streaming captured bins on m_*; waits on m_ready
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   s_valid/s_ready/s_i/s_q/s_last input sample stream
//   fft_in_phase/fft_in_quad       frame to FFT, word k at [W*k +: W]
//   fft_out_phase/fft_out_quad     FFT result, bin k at [W*k +: W]
//   m_valid/m_ready/m_i/m_q        output bin stream
//   m_bin, m_last                  current bin index, high on bin 7
//   busy                           high in COMPUTE or DRAIN
//   err_short, err_long            one-cycle pulses, registered, so they
//                                  appear the cycle after the offending sample
//   frame_count                    completed frames, wraps
module fft8_frame_ctrl #(
    parameter int W       = 16,
    parameter int FFT_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_i,
    input  logic [W-1:0]   s_q,
    input  logic           s_last,
    output logic [8*W-1:0] fft_in_phase,
    output logic [8*W-1:0] fft_in_quad,
    input  logic [8*W-1:0] fft_out_phase,
    input  logic [8*W-1:0] fft_out_quad,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_i,
    output logic [W-1:0]   m_q,
    output logic [2:0]     m_bin,
    output logic           m_last,
    output logic           busy,
    output logic           err_short,
    output logic           err_long,
    output logic [15:0]    frame_count
);

    localparam int CW = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;

    typedef enum logic [1:0] {FILL, COMPUTE, DRAIN} state_t;

    state_t         state_q, state_d;
    logic           s_ready_q;
    logic [2:0]     wr_idx_q, rd_idx_q;
    logic [CW-1:0]  lat_cnt_q;
    logic [W-1:0]   in_i_q [8];
    logic [W-1:0]   in_q_q [8];
    logic [W-1:0]   cap_i_q[8];
    logic [W-1:0]   cap_q_q[8];
    logic           err_short_q, err_long_q;
    logic [15:0]    frame_count_q;

    logic accept, close, lat_done, beat, beat_last;

    assign accept    = (state_q == FILL) && s_valid && s_ready_q;
    assign close     = accept && ((wr_idx_q == 3'd7) || s_last);
    assign lat_done  = (state_q == COMPUTE) && (lat_cnt_q == '0);
    assign beat      = (state_q == DRAIN) && m_ready;
    assign beat_last = beat && (rd_idx_q == 3'd7);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (close)     state_d = COMPUTE;
            COMPUTE: if (lat_done)  state_d = DRAIN;
            DRAIN:   if (beat_last) state_d = FILL;
            default:                state_d = FILL;
        endcase
    end

    always_comb begin
        fft_in_phase = '0;
        fft_in_quad  = '0;
        for (int k = 0; k < 8; k++) begin
            fft_in_phase[W*k +: W] = in_i_q[k];
            fft_in_quad[W*k +: W]  = in_q_q[k];
        end
        m_valid = (state_q == DRAIN);
        m_i     = m_valid ? cap_i_q[rd_idx_q] : '0;
        m_q     = m_valid ? cap_q_q[rd_idx_q] : '0;
        m_last  = m_valid && (rd_idx_q == 3'd7);
    end

    assign s_ready     = s_ready_q;
    assign m_bin       = rd_idx_q;
    assign busy        = (state_q != FILL);
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign frame_count = frame_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            s_ready_q     <= 1'b0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            lat_cnt_q     <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            frame_count_q <= '0;
            for (int k = 0; k < 8; k++) begin
                in_i_q[k]  <= '0;
                in_q_q[k]  <= '0;
                cap_i_q[k] <= '0;
                cap_q_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            // registered so s_ready stays low until the first edge out of reset
            s_ready_q   <= (state_d == FILL);
            err_short_q <= close && s_last && (wr_idx_q != 3'd7);
            err_long_q  <= accept && (wr_idx_q == 3'd7) && !s_last;

            if (accept)
                wr_idx_q <= close ? 3'd0 : wr_idx_q + 3'd1;

            for (int k = 0; k < 8; k++) begin
                if (accept) begin
                    if (3'(k) == wr_idx_q) begin
                        in_i_q[k] <= s_i;
                        in_q_q[k] <= s_q;
                    end else if (s_last && (3'(k) > wr_idx_q)) begin
                        in_i_q[k] <= '0;
                        in_q_q[k] <= '0;
                    end
                end else if (beat_last) begin
                    in_i_q[k] <= '0;
                    in_q_q[k] <= '0;
                end
                if (lat_done) begin
                    cap_i_q[k] <= fft_out_phase[W*k +: W];
                    cap_q_q[k] <= fft_out_quad[W*k +: W];
                end
            end

            if (close)
                lat_cnt_q <= CW'(FFT_LAT - 1);
            else if ((state_q == COMPUTE) && (lat_cnt_q != '0))
                lat_cnt_q <= lat_cnt_q - 1'b1;

            // 3-bit index wraps back to 0 after bin 7
            if (beat)
                rd_idx_q <= rd_idx_q + 3'd1;

            if (beat_last)
                frame_count_q <= frame_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Testbench for fft8_frame_ctrl.
//   dut_a: FFT_LAT=1 with identity FFT stub, checked every cycle against a
//          transaction-level model (frame words, expected-beat queue).
//   dut_b: FFT_LAT=3 with a registered identity stub whose result settles
//          within the latency window; checks first-valid timing and data.
module tb_fft8_frame_ctrl;
    localparam int W     = 16;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic           a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last;
    logic           a_busy, a_err_s, a_err_l;
    logic [W-1:0]   a_s_i, a_s_q, a_m_i, a_m_q;
    logic [2:0]     a_m_bin;
    logic [15:0]    a_fc;
    logic [8*W-1:0] a_fin_p, a_fin_q, a_fout_p, a_fout_q;

    logic           b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
    logic           b_busy, b_err_s, b_err_l;
    logic [W-1:0]   b_s_i, b_s_q, b_m_i, b_m_q;
    logic [2:0]     b_m_bin;
    logic [15:0]    b_fc;
    logic [8*W-1:0] b_fin_p, b_fin_q, b_fout_p, b_fout_q, b_p1, b_q1;

    assign a_fout_p = a_fin_p;
    assign a_fout_q = a_fin_q;

    always @(posedge clk) begin
        b_p1     <= b_fin_p;
        b_q1     <= b_fin_q;
        b_fout_p <= b_p1;
        b_fout_q <= b_q1;
    end

    fft8_frame_ctrl #(.W(W), .FFT_LAT(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_i(a_s_i), .s_q(a_s_q), .s_last(a_s_last),
        .fft_in_phase(a_fin_p), .fft_in_quad(a_fin_q),
        .fft_out_phase(a_fout_p), .fft_out_quad(a_fout_q),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_i(a_m_i), .m_q(a_m_q),
        .m_bin(a_m_bin), .m_last(a_m_last), .busy(a_busy),
        .err_short(a_err_s), .err_long(a_err_l), .frame_count(a_fc)
    );

    fft8_frame_ctrl #(.W(W), .FFT_LAT(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_i(b_s_i), .s_q(b_s_q), .s_last(b_s_last),
        .fft_in_phase(b_fin_p), .fft_in_quad(b_fin_q),
        .fft_out_phase(b_fout_p), .fft_out_quad(b_fout_q),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_i(b_m_i), .m_q(b_m_q),
        .m_bin(b_m_bin), .m_last(b_m_last), .busy(b_busy),
        .err_short(b_err_s), .err_long(b_err_l), .frame_count(b_fc)
    );

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [2:0]  bin;
        logic        last;
    } beat_t;

    int n_pass = 0;
    int n_total = 0;
    int mr_mode = 0;

    // model state for dut_a
    bit          in_fill;
    int          lat_left;
    int          wr;
    logic [15:0] wi[8];
    logic [15:0] wq[8];
    beat_t       expq[$];
    logic [15:0] mfc;
    bit          e_short, e_long;

    logic [15:0] bi[8];
    logic [15:0] bq[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    function automatic logic [127:0] pack(input logic [15:0] w [8]);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = w[k];
        return r;
    endfunction

    task automatic model_reset();
        in_fill  = 1'b1;
        lat_left = 0;
        wr       = 0;
        mfc      = '0;
        e_short  = 1'b0;
        e_long   = 1'b0;
        expq.delete();
        for (int k = 0; k < 8; k++) begin
            wi[k] = '0;
            wq[k] = '0;
        end
    endtask

    task automatic monitor_step();
        bit draining;
        bit lst;
        beat_t b;
        draining = !in_fill && (lat_left == 0);
        chk("s_ready", 128'(a_s_ready), 128'(in_fill));
        chk("busy", 128'(a_busy), 128'(!in_fill));
        chk("m_valid", 128'(a_m_valid), 128'(draining));
        if (draining && expq.size() > 0) begin
            chk("m_i", 128'(a_m_i), 128'(expq[0].i));
            chk("m_q", 128'(a_m_q), 128'(expq[0].q));
            chk("m_bin", 128'(a_m_bin), 128'(expq[0].bin));
            chk("m_last", 128'(a_m_last), 128'(expq[0].last));
        end
        chk("fft_in_phase", a_fin_p, pack(wi));
        chk("fft_in_quad", a_fin_q, pack(wq));
        chk("err_short", 128'(a_err_s), 128'(e_short));
        chk("err_long", 128'(a_err_l), 128'(e_long));
        chk("frame_count", 128'(a_fc), 128'(mfc));

        e_short = 1'b0;
        e_long  = 1'b0;
        if (in_fill) begin
            if (a_s_valid) begin
                wi[wr] = a_s_i;
                wq[wr] = a_s_q;
                if (wr == 7 || a_s_last) begin
                    e_short = (wr < 7);
                    e_long  = (wr == 7) && !a_s_last;
                    for (int k = 0; k < 8; k++) begin
                        b.i = wi[k]; b.q = wq[k]; b.bin = 3'(k); b.last = (k == 7);
                        expq.push_back(b);
                    end
                    in_fill  = 1'b0;
                    lat_left = LAT_A;
                    wr       = 0;
                end else begin
                    wr++;
                end
            end
        end else if (lat_left > 0) begin
            lat_left--;
        end else if (a_m_ready && expq.size() > 0) begin
            lst = expq[0].last;
            void'(expq.pop_front());
            if (lst) begin
                mfc++;
                in_fill = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    wi[k] = '0;
                    wq[k] = '0;
                end
            end
        end
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q, input bit last);
        bit ok;
        ok = 1'b0;
        a_s_valid = 1'b1;
        a_s_i = i;
        a_s_q = q;
        a_s_last = last;
        for (int t = 0; t < 200 && !ok; t++) begin
            ok = a_s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) timeout_fail("send");
        a_s_valid = 1'b0;
        a_s_last = 1'b0;
    endtask

    task automatic wait_frames(input logic [15:0] target);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            if (a_fc == target) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) timeout_fail("wait_frames");
    endtask

    // sync=1: assert at posedge+3; sync=0: assert 1 time unit from now
    task automatic do_reset(input bit sync);
        if (sync) begin
            @(posedge clk);
            #3;
        end else begin
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_s_ready", 128'(a_s_ready), 128'(0));
        chk("rst_m_valid", 128'(a_m_valid), 128'(0));
        chk("rst_m_bin", 128'(a_m_bin), 128'(0));
        chk("rst_m_i", 128'(a_m_i), 128'(0));
        chk("rst_busy", 128'(a_busy), 128'(0));
        chk("rst_frame_count", 128'(a_fc), 128'(0));
        chk("rst_fft_in", a_fin_p | a_fin_q, 128'(0));
        chk("rst_err", 128'({a_err_s, a_err_l, a_m_last}), 128'(0));
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", 128'(a_s_ready), 128'(1));
    endtask

    initial begin
        bit found;
        int cnt;
        logic [3:0] pat;
        a_s_valid = 0; a_s_i = 0; a_s_q = 0; a_s_last = 0; a_m_ready = 1;
        b_s_valid = 0; b_s_i = 0; b_s_q = 0; b_s_last = 0; b_m_ready = 1;
        pat = 4'b1001;
        model_reset();

        fork
            forever begin
                @(negedge clk or negedge rst_n);
                if (!rst_n) model_reset();
                else monitor_step();
            end
            begin
                int cyc;
                cyc = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    case (mr_mode)
                        0: a_m_ready = 1'b1;
                        1: a_m_ready = pat[cyc % 4];
                        2: a_m_ready = 1'($urandom_range(1));
                        default: a_m_ready = 1'b0;
                    endcase
                    cyc++;
                end
            end
            begin
                #2000000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1, "watchdog");
            end
        join_none

        // power-on reset
        do_reset(1'b0);

        // impulse frame
        for (int k = 0; k < 8; k++)
            send(k == 2 ? 16'h0014 : 16'h0, k == 2 ? 16'h0028 : 16'h0, k == 7);
        chk("imp_fft_in_phase", a_fin_p, 128'h0000_0000_0000_0000_0000_0014_0000_0000);
        chk("imp_fft_in_quad", a_fin_q, 128'h0000_0000_0000_0000_0000_0028_0000_0000);
        chk("imp_busy", 128'(a_busy), 128'(1));
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(posedge clk);
            #1;
            if (a_m_valid && a_m_bin == 3'd2) begin
                found = 1'b1;
                chk("imp_bin2_i", 128'(a_m_i), 128'(16'h0014));
                chk("imp_bin2_q", 128'(a_m_q), 128'(16'h0028));
            end
        end
        if (!found) timeout_fail("imp_bin2");
        wait_frames(16'd1);
        chk("imp_frame_count", 128'(a_fc), 128'(1));

        // backpressure 1,0,0,1,...
        mr_mode = 1;
        for (int k = 0; k < 8; k++) send(16'($urandom), 16'($urandom), k == 7);
        wait_frames(16'd2);
        mr_mode = 0;

        // short frame
        send(16'h000A, 16'h000A, 1'b0);
        send(16'h001E, 16'h001E, 1'b0);
        send(16'h0028, 16'h0028, 1'b1);
        chk("short_err_pulse", 128'(a_err_s), 128'(1));
        chk("short_fft_in", a_fin_p, 128'h0000_0000_0000_0000_0000_0028_001E_000A);
        @(posedge clk);
        #1;
        chk("short_err_once", 128'(a_err_s), 128'(0));
        wait_frames(16'd3);

        // long frames: two back-to-back 8-sample frames without s_last
        for (int k = 0; k < 8; k++) send(16'($urandom), 16'($urandom), 1'b0);
        chk("long_err_pulse", 128'(a_err_l), 128'(1));
        for (int k = 0; k < 8; k++) send(16'($urandom), 16'($urandom), 1'b0);
        wait_frames(16'd5);
        chk("long_frame_count", 128'(a_fc), 128'(5));

        // randomized traffic
        mr_mode = 2;
        for (int c = 0; c < 800; c++) begin
            a_s_valid = ($urandom_range(3) != 0);
            a_s_i = 16'($urandom);
            a_s_q = 16'($urandom);
            a_s_last = ($urandom_range(5) == 0);
            @(posedge clk);
            #1;
        end
        a_s_valid = 1'b0;
        a_s_last = 1'b0;
        mr_mode = 0;
        do_reset(1'b1);

        // async reset during drain at bin 4
        for (int k = 0; k < 8; k++) send(16'(k + 1), 16'(k + 9), k == 7);
        found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(posedge clk);
            #2;
            if (a_m_valid && a_m_bin == 3'd4) found = 1'b1;
        end
        if (!found) timeout_fail("reach_bin4");
        mr_mode = 3;
        a_m_ready = 1'b0;
        do_reset(1'b0);
        mr_mode = 0;
        for (int k = 0; k < 8; k++) send(16'($urandom), 16'($urandom), k == 7);
        wait_frames(16'd1);
        chk("post_rst_frame_count", 128'(a_fc), 128'(1));

        // FFT_LAT=3 instance
        for (int k = 0; k < 8; k++) begin
            bi[k] = 16'($urandom);
            bq[k] = 16'($urandom);
            chk("lat_s_ready", 128'(b_s_ready), 128'(1));
            b_s_valid = 1'b1;
            b_s_i = bi[k];
            b_s_q = bq[k];
            b_s_last = (k == 7);
            @(posedge clk);
            #1;
        end
        b_s_valid = 1'b0;
        b_s_last = 1'b0;
        cnt = 0;
        while (!b_m_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("lat_first_valid", 128'(cnt), 128'(LAT_B));
        for (int k = 0; k < 8; k++) begin
            chk("lat_m_valid", 128'(b_m_valid), 128'(1));
            chk("lat_m_bin", 128'(b_m_bin), 128'(k));
            chk("lat_m_i", 128'(b_m_i), 128'(bi[k]));
            chk("lat_m_q", 128'(b_m_q), 128'(bq[k]));
            chk("lat_m_last", 128'(b_m_last), 128'(k == 7));
            @(posedge clk);
            #1;
        end
        chk("lat_frame_count", 128'(b_fc), 128'(1));
        chk("lat_idle", 128'(b_m_valid), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
